opb_bus_master: RTL

//  Single-outstanding OPB bus initiator: the driving end of the address-decoded peripheral bus.

---
 rtl/opb_bus_master.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/opb_bus_master.sv
// rtl/opb_bus_master.sv - single-outstanding OPB bus initiator with parameterised strobe width and turnaround
module opb_bus_master #(
    parameter int STROBE_CYCLES = 1,
    parameter int TURNAROUND    = 1
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WR,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic        RSP_WR,
    output logic [31:0] RSP_RDATA,
    output logic [31:0] DEC_ADDR,
    output logic        DEC_RE,
    output logic        DEC_WE,
    output logic [31:0] OPB_DO,
    input  logic [31:0] DEC_DO,
    output logic        BUSY
);
    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP, S_RESP} state_t;

    localparam logic [3:0] C_STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] C_GAP_LOAD    = 4'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);
    localparam bit         C_HAS_GAP     = (TURNAROUND > 0);

    state_t      r_state, w_state;
    logic [3:0]  r_cnt, w_cnt;
    logic        r_wr, w_wr;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic        r_re, w_re;
    logic        r_we, w_we;
    logic        r_req_ready, w_req_ready;
    logic        r_rsp_valid, w_rsp_valid;
    logic        r_rsp_wr, w_rsp_wr;
    logic [31:0] r_rsp_rdata, w_rsp_rdata;
    logic        r_busy, w_busy;

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_wr        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_re        <= 1'b0;
            r_we        <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_wr        <= w_wr;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_re        <= w_re;
            r_we        <= w_we;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_wr    <= w_rsp_wr;
            r_rsp_rdata <= w_rsp_rdata;
            r_busy      <= w_busy;
        end
    end

    // Every output is computed one cycle ahead so that all ports come straight from flops.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_wr        = r_wr;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_re        = r_re;
        w_we        = r_we;
        w_req_ready = r_req_ready;
        w_rsp_valid = r_rsp_valid;
        w_rsp_wr    = r_rsp_wr;
        w_rsp_rdata = r_rsp_rdata;
        w_busy      = r_busy;
        case (r_state)
            S_IDLE: begin
                if (REQ_VALID) begin
                    w_addr      = REQ_ADDR;
                    w_wdata     = REQ_WDATA;
                    w_wr        = REQ_WR;
                    w_re        = ~REQ_WR;
                    w_we        = REQ_WR;
                    w_cnt       = C_STROBE_LOAD;
                    w_req_ready = 1'b0;
                    w_busy      = 1'b1;
                    w_state     = S_STROBE;
                end
            end
            S_STROBE: begin
                if (r_cnt == 4'd0) begin
                    // DEC_DO is only valid while DEC_RE is high, so sample on the last strobe edge.
                    w_re        = 1'b0;
                    w_we        = 1'b0;
                    w_rsp_wr    = r_wr;
                    w_rsp_rdata = r_wr ? 32'd0 : DEC_DO;
                    if (C_HAS_GAP) begin
                        w_cnt   = C_GAP_LOAD;
                        w_state = S_GAP;
                    end else begin
                        w_rsp_valid = 1'b1;
                        w_state     = S_RESP;
                    end
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == 4'd0) begin
                    w_rsp_valid = 1'b1;
                    w_state     = S_RESP;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                    w_busy      = 1'b0;
                    w_state     = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign REQ_READY = r_req_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_WR    = r_rsp_wr;
    assign RSP_RDATA = r_rsp_rdata;
    assign DEC_ADDR  = r_addr;
    assign DEC_RE    = r_re;
    assign DEC_WE    = r_we;
    assign OPB_DO    = r_wdata;
    assign BUSY      = r_busy;
endmodule
